// File: rtl/dm_lsu.sv
// Load/store unit driving a single-port word-wide data memory; sub-word stores are read-modify-write.
// Optional: define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them down.
module dm_lsu #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    output logic              dm_we,
    input  logic [31:0]       dm_rd
);

    typedef enum logic [2:0] {S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       dm_wd_q, dm_wd_d;
    logic              dm_we_q, dm_we_d;

    logic        req_bad_f3, req_oor, req_misal, req_err, req_sw;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext, merged;

    always_comb begin
        req_bad_f3 = req_we ? (req_funct3 >= 3'd3)
                            : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
        req_oor    = |req_addr[31:ADDR_W+2];
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   req_misal = req_addr[0];
            2'b10:   req_misal = |req_addr[1:0];
            default: req_misal = 1'b0;
        endcase
`else
        req_misal  = 1'b0;
`endif
        req_err    = req_bad_f3 || req_oor || req_misal;
        req_sw     = req_we && (req_funct3 == 3'd2);
    end

    // Halfword lane uses only lane_q[1], so an untrapped misaligned halfword is aligned down.
    always_comb begin
        rd_byte = dm_rd[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (f3_q)
            3'd0:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_ext = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_ext = {24'd0, rd_byte};
            3'd5:    load_ext = {16'd0, rd_half};
            default: load_ext = dm_rd;
        endcase
        merged = dm_rd;
        if (f3_q[1:0] == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        dm_addr_d   = dm_addr_q;
        dm_wd_d     = dm_wd_q;
        dm_we_d     = 1'b0;
        req_ready   = (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (req_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        dm_addr_d = req_addr[ADDR_W+1:2];
                        if (req_sw) begin
                            state_d = S_WR;
                            dm_we_d = 1'b1;
                            dm_wd_d = req_wdata;
                        end else begin
                            state_d = S_RD_ISSUE;
                        end
                    end
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (we_q) begin
                    state_d = S_WR;
                    dm_we_d = 1'b1;
                    dm_wd_d = merged;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext;
                end
            end
            S_WR: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            dm_addr_q   <= '0;
            dm_wd_q     <= 32'd0;
            dm_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            dm_addr_q   <= dm_addr_d;
            dm_wd_q     <= dm_wd_d;
            dm_we_q     <= dm_we_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wd     = dm_wd_q;
    assign dm_we     = dm_we_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu with a behavioural synchronous-read data memory.
module tb_dm_lsu;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wd;
    logic              dm_we;
    logic [31:0]       dm_rd;

    logic [31:0] mem [2**ADDR_W];

    int checks = 0;
    int errors = 0;

    logic [31:0] r_rd;
    logic        r_err;
    int          r_lat, r_wecnt, r_wefirst;
    logic        r_idle;

    dm_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wd;
        dm_rd <= mem[dm_addr];
    end

    // Issues one request from an IDLE DUT and records latency (edges after accept), write pulses and response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = -1; r_wecnt = 0; r_wefirst = -1; r_rd = 32'd0; r_err = 1'b0; r_idle = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (dm_we === 1'b1) begin
                r_wecnt++;
                if (r_wefirst < 0) r_wefirst = k;
            end
            if (rsp_valid === 1'b1) begin
                r_lat = k; r_rd = rsp_rdata; r_err = rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_idle = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b exp 0", rsp_err); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp_rdata: got %h exp 0", rsp_rdata); end
        checks++; if (dm_addr !== '0) begin errors++; $display("FAIL rst_dm_addr: got %h exp 0", dm_addr); end
        checks++; if (dm_wd !== 32'd0) begin errors++; $display("FAIL rst_dm_wd: got %h exp 0", dm_wd); end
        checks++; if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_dm_we: got %b exp 0", dm_we); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        do_req(1'b1, 3'd2, 32'h08, 32'hDEADBEEF);
        checks++; if (r_lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d exp 1", r_lat); end
        checks++; if (r_wecnt !== 1 || r_wefirst !== 0) begin errors++; $display("FAIL sw_we: count %0d first %0d exp 1/0", r_wecnt, r_wefirst); end
        checks++; if (r_err !== 1'b0 || r_rd !== 32'd0) begin errors++; $display("FAIL sw_rsp: err %b data %h exp 0/0", r_err, r_rd); end
        checks++; if (r_idle !== 1'b1) begin errors++; $display("FAIL sw_pulse: idle %b exp 1", r_idle); end
        do_req(1'b0, 3'd2, 32'h08, 32'h0);
        checks++; if (r_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h exp deadbeef", r_rd); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b exp 0", r_err); end
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d exp 2", r_lat); end
        checks++; if (r_wecnt !== 0) begin errors++; $display("FAIL lw_we: got %0d exp 0", r_wecnt); end
        checks++; if (r_idle !== 1'b1) begin errors++; $display("FAIL lw_pulse: idle %b exp 1", r_idle); end
    endtask

    task automatic test_subword_store();
        do_req(1'b1, 3'd0, 32'h09, 32'hAABBCC55);
        checks++; if (r_lat !== 3) begin errors++; $display("FAIL sb_latency: got %0d exp 3", r_lat); end
        checks++; if (r_wecnt !== 1 || r_wefirst !== 2) begin errors++; $display("FAIL sb_we: count %0d first %0d exp 1/2", r_wecnt, r_wefirst); end
        do_req(1'b0, 3'd2, 32'h08, 32'h0);
        checks++; if (r_rd !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_merge: got %h exp dead55ef", r_rd); end
        do_req(1'b1, 3'd2, 32'h10, 32'h11223344);
        do_req(1'b1, 3'd1, 32'h12, 32'h1234ABCD);
        checks++; if (r_lat !== 3 || r_wecnt !== 1) begin errors++; $display("FAIL sh_timing: lat %0d we %0d exp 3/1", r_lat, r_wecnt); end
        do_req(1'b0, 3'd2, 32'h10, 32'h0);
        checks++; if (r_rd !== 32'hABCD3344) begin errors++; $display("FAIL sh_merge: got %h exp abcd3344", r_rd); end
    endtask

    task automatic test_extend();
        do_req(1'b1, 3'd2, 32'h0C, 32'h0000F080);
        do_req(1'b0, 3'd0, 32'h0C, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb: got %h exp ffffff80", r_rd); end
        do_req(1'b0, 3'd4, 32'h0C, 32'h0);
        checks++; if (r_rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h exp 00000080", r_rd); end
        do_req(1'b0, 3'd1, 32'h0C, 32'h0);
        checks++; if (r_rd !== 32'hFFFFF080) begin errors++; $display("FAIL lh: got %h exp fffff080", r_rd); end
        do_req(1'b0, 3'd5, 32'h0C, 32'h0);
        checks++; if (r_rd !== 32'h0000F080) begin errors++; $display("FAIL lhu: got %h exp 0000f080", r_rd); end
        do_req(1'b0, 3'd0, 32'h0D, 32'h0);
        checks++; if (r_rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_lane1: got %h exp fffffff0", r_rd); end
        do_req(1'b0, 3'd1, 32'h0A, 32'h0);
        checks++; if (r_rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh_upper: got %h exp ffffdead", r_rd); end
    endtask

    task automatic test_errors();
        do_req(1'b1, 3'd2, 32'h7C, 32'h13579BDF);
        do_req(1'b0, 3'd2, 32'h7C, 32'h0);
        checks++; if (r_rd !== 32'h13579BDF || r_err !== 1'b0) begin errors++; $display("FAIL top_word: got %h err %b exp 13579bdf/0", r_rd, r_err); end
        do_req(1'b0, 3'd2, 32'h80, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin errors++; $display("FAIL oor_lw: err %b data %h exp 1/0", r_err, r_rd); end
        checks++; if (r_wecnt !== 0 || r_lat !== 0) begin errors++; $display("FAIL oor_timing: we %0d lat %0d exp 0/0", r_wecnt, r_lat); end
        do_req(1'b1, 3'd2, 32'hFFFFFFFC, 32'h0);
        checks++; if (r_err !== 1'b1 || r_wecnt !== 0) begin errors++; $display("FAIL oor_sw: err %b we %0d exp 1/0", r_err, r_wecnt); end
        do_req(1'b0, 3'd3, 32'h08, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin errors++; $display("FAIL ld_f3_3: err %b data %h exp 1/0", r_err, r_rd); end
        do_req(1'b0, 3'd6, 32'h08, 32'h0);
        checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL ld_f3_6: err %b exp 1", r_err); end
        do_req(1'b1, 3'd4, 32'h08, 32'h0);
        checks++; if (r_err !== 1'b1 || r_wecnt !== 0) begin errors++; $display("FAIL st_f3_4: err %b we %0d exp 1/0", r_err, r_wecnt); end
        do_req(1'b0, 3'd2, 32'h08, 32'h0);
        checks++; if (r_rd !== 32'hDEAD55EF) begin errors++; $display("FAIL st_err_nowrite: got %h exp dead55ef", r_rd); end
    endtask

    task automatic test_misalign();
        do_req(1'b0, 3'd2, 32'h0A, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin errors++; $display("FAIL mis_lw: err %b data %h exp 1/0", r_err, r_rd); end
`else
        checks++; if (r_err !== 1'b0 || r_rd !== 32'hDEAD55EF) begin errors++; $display("FAIL mis_lw: err %b data %h exp 0/dead55ef", r_err, r_rd); end
`endif
        do_req(1'b0, 3'd1, 32'h0D, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (r_err !== 1'b1 || r_rd !== 32'd0) begin errors++; $display("FAIL mis_lh: err %b data %h exp 1/0", r_err, r_rd); end
`else
        checks++; if (r_err !== 1'b0 || r_rd !== 32'hFFFFF080) begin errors++; $display("FAIL mis_lh: err %b data %h exp 0/fffff080", r_err, r_rd); end
`endif
        do_req(1'b1, 3'd2, 32'h7D, 32'h0BADCAFE);
        do_req(1'b0, 3'd2, 32'h7C, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (r_rd !== 32'h13579BDF) begin errors++; $display("FAIL mis_sw: got %h exp 13579bdf", r_rd); end
`else
        checks++; if (r_rd !== 32'h0BADCAFE) begin errors++; $display("FAIL mis_sw: got %h exp 0badcafe", r_rd); end
`endif
    endtask

    task automatic test_reset_mid_store();
        do_req(1'b1, 3'd2, 32'h14, 32'hCAFEF00D);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h16; req_wdata = 32'h00001111;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b exp 0", req_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (dm_we !== 1'b1) begin errors++; $display("FAIL sh_in_wr: dm_we %b exp 1", dm_we); end
        rst_n = 1'b0;
        #1;
        checks++; if (dm_we !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rst_abort: dm_we %b ready %b exp 0/1", dm_we, req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 3'd2, 32'h14, 32'h0);
        checks++; if (r_rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_no_write: got %h exp cafef00d", r_rd); end
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 32'd0;
        test_reset();
        test_word();
        test_subword_store();
        test_extend();
        test_errors();
        test_misalign();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
